// File: rtl/plab4_net_domain_pkg.sv
// -----------------------------------------------------------------------------
// plab4_net_domain_pkg
// Shared definitions for the two-domain network ingress arbiter:
//   - domain encodings (D1 = 0, D2 = 1)
//   - reset value of the round-robin "last granted" register
//   - helper to turn a one-hot two-way grant into a domain index
// -----------------------------------------------------------------------------
package plab4_net_domain_pkg;

    localparam logic DOMAIN_D1 = 1'b0;
    localparam logic DOMAIN_D2 = 1'b1;

    // Resetting to D2 makes D1 the winner of the first tie after reset.
    localparam logic LAST_GRANT_RST = DOMAIN_D2;

    // grant[0] belongs to D1, grant[1] to D2; an all-zero grant maps to D1.
    function automatic logic grant_to_domain(input logic [1:0] grant);
        return grant[1] ? DOMAIN_D2 : DOMAIN_D1;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb2.sv
// -----------------------------------------------------------------------------
// plab4_net_rr_arb2
// Two-requester round-robin arbiter. The grant is purely combinational from
// req and the last_grant register; last_grant only advances when the granted
// request is actually accepted (fire), so a stalled grant never rotates
// priority.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   req    in   [1:0] request vector (bit 0 = D1, bit 1 = D2)
//   fire   in   granted request was accepted this cycle
//   grant  out  [1:0] one-hot grant (or zero when nothing requests)
// -----------------------------------------------------------------------------
module plab4_net_rr_arb2
    import plab4_net_domain_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       fire,
    output logic [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the domain that did not win last time goes first.
            2'b11:   grant = (r_last_grant == DOMAIN_D2) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (fire) begin
            r_last_grant <= grant_to_domain(grant);
        end
    end

endmodule

// File: rtl/plab4_net_domain_arb.sv
// -----------------------------------------------------------------------------
// plab4_net_domain_arb
// Merges the D1 and D2 ingress message streams into a single tagged stream.
// A one-entry registered slot sits on the output so out_val, out_msg_* and
// domain are pure register outputs; the slot can refill in the same cycle it
// drains, giving one message per cycle when out_rdy is held high.
//
// Parameters:
//   p_msg_cnbits  control-message width
//   p_msg_dnbits  data-message width
//
// Ports:
//   clk                in   clock, rising edge
//   reset              in   asynchronous active-low reset
//   in_val_d1/_d2      in   domain message valid
//   in_rdy_d1/_d2      out  domain message accepted this cycle
//   in_msg_control_dX  in   domain control payload
//   in_msg_data_dX     in   domain data payload
//   out_val            out  output slot holds a message
//   out_rdy            in   downstream accepts the message
//   out_msg_control    out  buffered control payload
//   out_msg_data       out  buffered data payload
//   domain             out  owner of the buffered message (0 = D1, 1 = D2)
// -----------------------------------------------------------------------------
module plab4_net_domain_arb
    import plab4_net_domain_pkg::*;
#(
    parameter int unsigned p_msg_cnbits = 32,
    parameter int unsigned p_msg_dnbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,
    output logic                    domain
);

    logic                    r_full;
    logic                    r_domain;
    logic [p_msg_cnbits-1:0] r_msg_control;
    logic [p_msg_dnbits-1:0] r_msg_data;

    logic [1:0]              w_req;
    logic [1:0]              w_grant;
    logic                    w_can_load;
    logic                    w_fire_d1;
    logic                    w_fire_d2;
    logic                    w_fire_in;
    logic                    w_drain;
    logic                    w_sel_domain;
    logic [p_msg_cnbits-1:0] w_sel_control;
    logic [p_msg_dnbits-1:0] w_sel_data;

    assign w_req = {in_val_d2, in_val_d1};

    plab4_net_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .fire  (w_fire_in),
        .grant (w_grant)
    );

    // An empty slot always loads; a full slot loads only while it drains.
    assign w_can_load = ~r_full | out_rdy;

    assign in_rdy_d1 = w_grant[0] & w_can_load;
    assign in_rdy_d2 = w_grant[1] & w_can_load;

    assign w_fire_d1 = in_val_d1 & in_rdy_d1;
    assign w_fire_d2 = in_val_d2 & in_rdy_d2;
    assign w_fire_in = w_fire_d1 | w_fire_d2;
    assign w_drain   = r_full & out_rdy;

    always_comb begin
        w_sel_domain  = grant_to_domain(w_grant);
        w_sel_control = w_grant[1] ? in_msg_control_d2 : in_msg_control_d1;
        w_sel_data    = w_grant[1] ? in_msg_data_d2    : in_msg_data_d1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full        <= 1'b0;
            r_domain      <= DOMAIN_D1;
            r_msg_control <= '0;
            r_msg_data    <= '0;
        end else if (w_fire_in) begin
            // Covers both a plain fill and a simultaneous drain+fill.
            r_full        <= 1'b1;
            r_domain      <= w_sel_domain;
            r_msg_control <= w_sel_control;
            r_msg_data    <= w_sel_data;
        end else if (w_drain) begin
            // Scrub the slot so no stale payload or tag stays visible.
            r_full        <= 1'b0;
            r_domain      <= DOMAIN_D1;
            r_msg_control <= '0;
            r_msg_data    <= '0;
        end
    end

    assign out_val         = r_full;
    assign out_msg_control = r_msg_control;
    assign out_msg_data    = r_msg_data;
    assign domain          = r_domain;

endmodule

// File: tb/tb_plab4_net_domain_arb.sv
module tb_plab4_net_domain_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val_d1, in_rdy_d1, in_val_d2, in_rdy_d2;
    logic [31:0] in_msg_control_d1, in_msg_data_d1;
    logic [31:0] in_msg_control_d2, in_msg_data_d2;
    logic        out_val, out_rdy, domain;
    logic [31:0] out_msg_control, out_msg_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    plab4_net_domain_arb #(
        .p_msg_cnbits (32),
        .p_msg_dnbits (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (in_val_d1),
        .in_rdy_d1         (in_rdy_d1),
        .in_msg_control_d1 (in_msg_control_d1),
        .in_msg_data_d1    (in_msg_data_d1),
        .in_val_d2         (in_val_d2),
        .in_rdy_d2         (in_rdy_d2),
        .in_msg_control_d2 (in_msg_control_d2),
        .in_msg_data_d2    (in_msg_data_d2),
        .out_val           (out_val),
        .out_rdy           (out_rdy),
        .out_msg_control   (out_msg_control),
        .out_msg_data      (out_msg_data),
        .domain            (domain)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_val_d1 = 1'b0; in_msg_control_d1 = '0; in_msg_data_d1 = '0;
        in_val_d2 = 1'b0; in_msg_control_d2 = '0; in_msg_data_d2 = '0;
        out_rdy   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        total++;
        if ({out_val, domain, out_msg_control, out_msg_data} !== 66'd0)
            $display("FAIL reset_initial: got val=%b dom=%b ctl=%h dat=%h, want all zero",
                     out_val, domain, out_msg_control, out_msg_data);
        else passed++;
        tick();
        reset = 1'b1;
        #1;
        // Buffer a D2 message, then reset mid-cycle while the slot is full.
        in_val_d2 = 1'b1; in_msg_control_d2 = 32'hC077; in_msg_data_d2 = 32'h77;
        tick();
        in_val_d2 = 1'b0;
        total++;
        if ({out_val, domain, out_msg_data} !== {1'b1, 1'b1, 32'h77})
            $display("FAIL reset_preload: got val=%b dom=%b dat=%h, want 1 1 00000077",
                     out_val, domain, out_msg_data);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({out_val, domain, out_msg_control, out_msg_data} !== 66'd0)
            $display("FAIL reset_async: got val=%b dom=%b ctl=%h dat=%h, want all zero",
                     out_val, domain, out_msg_control, out_msg_data);
        else passed++;
        tick();
        reset = 1'b1;
        #1;
        in_val_d1 = 1'b1; in_val_d2 = 1'b1;
        #2;
        total++;
        if ({in_rdy_d1, in_rdy_d2} !== 2'b10)
            $display("FAIL reset_first_tie: got rdy_d1=%b rdy_d2=%b, want 1 0", in_rdy_d1, in_rdy_d2);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_single_domain();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_val_d1 = 1'b1;
            in_msg_control_d1 = 32'h11 + i;
            in_msg_data_d1    = 32'hA0 + i;
            #2;
            total++;
            if ({in_rdy_d1, in_rdy_d2} !== 2'b10)
                $display("FAIL single_rdy[%0d]: got rdy_d1=%b rdy_d2=%b, want 1 0", i, in_rdy_d1, in_rdy_d2);
            else passed++;
            tick();
            total++;
            if ({out_val, domain, out_msg_control, out_msg_data} !== {1'b1, 1'b0, 32'h11 + i, 32'hA0 + i})
                $display("FAIL single_out[%0d]: got val=%b dom=%b ctl=%h dat=%h, want 1 0 %h %h",
                         i, out_val, domain, out_msg_control, out_msg_data, 32'h11 + i, 32'hA0 + i);
            else passed++;
        end
        in_val_d1 = 1'b0;
        tick();
        total++;
        if ({out_val, domain, out_msg_data} !== 34'd0)
            $display("FAIL single_drained: got val=%b dom=%b dat=%h, want 0 0 0", out_val, domain, out_msg_data);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [31:0] exp_dat;
        logic        exp_dom;
        do_reset();
        out_rdy   = 1'b1;
        in_val_d1 = 1'b1; in_msg_control_d1 = 32'h100; in_msg_data_d1 = 32'h1;
        in_val_d2 = 1'b1; in_msg_control_d2 = 32'h200; in_msg_data_d2 = 32'h2;
        for (int i = 0; i < 6; i++) begin
            exp_dom = (i % 2 == 1);
            exp_dat = exp_dom ? 32'h2 : 32'h1;
            #2;
            total++;
            if ({in_rdy_d1, in_rdy_d2} !== {~exp_dom, exp_dom})
                $display("FAIL contention_rdy[%0d]: got rdy_d1=%b rdy_d2=%b, want %b %b",
                         i, in_rdy_d1, in_rdy_d2, ~exp_dom, exp_dom);
            else passed++;
            tick();
            total++;
            if ({out_val, domain, out_msg_data} !== {1'b1, exp_dom, exp_dat})
                $display("FAIL contention_out[%0d]: got val=%b dom=%b dat=%h, want 1 %b %h",
                         i, out_val, domain, out_msg_data, exp_dom, exp_dat);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_rdy   = 1'b1;
        in_val_d2 = 1'b1; in_msg_control_d2 = 32'hC055; in_msg_data_d2 = 32'h55;
        tick();
        // Both domains now request while the slot is stalled.
        out_rdy   = 1'b0;
        in_msg_control_d2 = 32'hC056; in_msg_data_d2 = 32'h56;
        in_val_d1 = 1'b1; in_msg_control_d1 = 32'hC066; in_msg_data_d1 = 32'h66;
        for (int i = 0; i < 4; i++) begin
            #2;
            total++;
            if ({in_rdy_d1, in_rdy_d2} !== 2'b00)
                $display("FAIL bp_rdy[%0d]: got rdy_d1=%b rdy_d2=%b, want 0 0", i, in_rdy_d1, in_rdy_d2);
            else passed++;
            tick();
            total++;
            if ({out_val, domain, out_msg_control, out_msg_data} !== {1'b1, 1'b1, 32'hC055, 32'h55})
                $display("FAIL bp_hold[%0d]: got val=%b dom=%b ctl=%h dat=%h, want 1 1 0000c055 00000055",
                         i, out_val, domain, out_msg_control, out_msg_data);
            else passed++;
        end
        out_rdy = 1'b1;
        #2;
        total++;
        if ({in_rdy_d1, in_rdy_d2} !== 2'b10)
            $display("FAIL bp_release_rdy: got rdy_d1=%b rdy_d2=%b, want 1 0", in_rdy_d1, in_rdy_d2);
        else passed++;
        tick();
        total++;
        if ({out_val, domain, out_msg_data} !== {1'b1, 1'b0, 32'h66})
            $display("FAIL bp_refill: got val=%b dom=%b dat=%h, want 1 0 00000066", out_val, domain, out_msg_data);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_drain_clear();
        do_reset();
        in_val_d2 = 1'b1; in_msg_control_d2 = 32'hBEEF; in_msg_data_d2 = 32'hDEAD;
        tick();
        in_val_d2 = 1'b0;
        total++;
        if ({out_val, domain, out_msg_control, out_msg_data} !== {1'b1, 1'b1, 32'hBEEF, 32'hDEAD})
            $display("FAIL drain_loaded: got val=%b dom=%b ctl=%h dat=%h, want 1 1 0000beef 0000dead",
                     out_val, domain, out_msg_control, out_msg_data);
        else passed++;
        out_rdy = 1'b1;
        tick();
        total++;
        if ({out_val, domain, out_msg_control, out_msg_data} !== 66'd0)
            $display("FAIL drain_cleared: got val=%b dom=%b ctl=%h dat=%h, want all zero",
                     out_val, domain, out_msg_control, out_msg_data);
        else passed++;
        idle_inputs();
    endtask

    // Reference model: slot + round-robin state tracked by the bench itself.
    // Payloads carry per-domain sequence numbers so loss, duplication and
    // reordering all show up as output mismatches.
    task automatic test_random();
        logic        m_full, m_dom, m_last;
        logic [31:0] m_ctl, m_dat;
        logic        g1, g2, can, f1, f2;
        int unsigned seq1, seq2;
        int          errs;
        do_reset();
        m_full = 1'b0; m_dom = 1'b0; m_last = 1'b1; m_ctl = '0; m_dat = '0;
        seq1 = 0; seq2 = 0; errs = 0;
        for (int cyc = 0; cyc < 10000 && errs < 5; cyc++) begin
            in_val_d1 = 1'($urandom_range(1, 0));
            in_val_d2 = 1'($urandom_range(1, 0));
            out_rdy   = 1'($urandom_range(3, 0) != 0);
            in_msg_control_d1 = 32'hC100_0000 | seq1; in_msg_data_d1 = 32'hD100_0000 | seq1;
            in_msg_control_d2 = 32'hC200_0000 | seq2; in_msg_data_d2 = 32'hD200_0000 | seq2;
            can = !m_full || out_rdy;
            if (in_val_d1 && in_val_d2) begin
                g1 = m_last; g2 = !m_last;
            end else begin
                g1 = in_val_d1; g2 = in_val_d2;
            end
            f1 = in_val_d1 && g1 && can;
            f2 = in_val_d2 && g2 && can;
            #2;
            total++;
            if ({in_rdy_d1, in_rdy_d2} !== {g1 && can, g2 && can}) begin
                $display("FAIL random_rdy[%0d]: got rdy_d1=%b rdy_d2=%b, want %b %b",
                         cyc, in_rdy_d1, in_rdy_d2, g1 && can, g2 && can);
                errs++;
            end else passed++;
            tick();
            if (f1 || f2) begin
                m_full = 1'b1;
                m_dom  = f2;
                m_last = f2;
                m_ctl  = f2 ? (32'hC200_0000 | seq2) : (32'hC100_0000 | seq1);
                m_dat  = f2 ? (32'hD200_0000 | seq2) : (32'hD100_0000 | seq1);
                if (f1) seq1++;
                if (f2) seq2++;
            end else if (m_full && out_rdy) begin
                m_full = 1'b0; m_dom = 1'b0; m_ctl = '0; m_dat = '0;
            end
            total++;
            if ({out_val, domain, out_msg_control, out_msg_data} !== {m_full, m_dom, m_ctl, m_dat}) begin
                $display("FAIL random_out[%0d]: got val=%b dom=%b ctl=%h dat=%h, want %b %b %h %h",
                         cyc, out_val, domain, out_msg_control, out_msg_data, m_full, m_dom, m_ctl, m_dat);
                errs++;
            end else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_single_domain();
        test_contention();
        test_backpressure();
        test_drain_clear();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/plab4_net_domain_arb.md
# plab4_net_domain_arb

Two-domain network ingress arbiter: merges the D1 (domain 0) and D2 (domain 1) message streams into one tagged stream. It drives `out_val`/`out_rdy`/`out_msg_control`/`out_msg_data` plus the `domain` select of the downstream domain demux. A one-entry registered output slot provides a full-throughput pipeline stage. Round-robin arbitration prevents either domain from starving the other, and the domain tag stays stable for the whole life of each buffered message.

## Interface
- `p_msg_cnbits`, 32, control-message width
- `p_msg_dnbits`, 32, data-message width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_val_d1`  in  1  D1 message valid
- `in_rdy_d1`  out  1  D1 message accepted this cycle
- `in_msg_control_d1`  in  p_msg_cnbits  D1 control payload
- `in_msg_data_d1`  in  p_msg_dnbits  D1 data payload
- `in_val_d2`, `in_rdy_d2`, `in_msg_control_d2`, `in_msg_data_d2`: same as D1, for D2
- `out_val`  out  1  output slot holds a message
- `out_rdy`  in  1  downstream accepts the message
- `out_msg_control`  out  p_msg_cnbits  buffered control payload
- `out_msg_data`  out  p_msg_dnbits  buffered data payload
- `domain`  out  1  owner of buffered message: 0 = D1, 1 = D2

## Operation
- **State:**
  - `full` (slot occupied)
  - slot payload registers
  - `domain` register
  - `last_grant` (domain granted most recently)
- **Reset values:** `full`=0, `out_val`=0, `domain`=0, `out_msg_control`=0, `out_msg_data`=0, `last_grant`=1. With `last_grant`=1, D1 wins the first tie.
- **Slot can load:** `can_load = ~full | out_rdy`.
- **Grant:**
  - Only one valid requester: it is granted.
  - Both valid: the domain ≠ `last_grant` is granted.
  - Neither valid: no grant.
- **Ready outputs:** `in_rdy_dX = grant_dX & can_load`. Combinational. At most one is high per cycle. The losing domain sees rdy=0.
- **Fire:** `fire_in = in_val_dX & in_rdy_dX`. On fire_in:
  - the slot loads the granted payload;
  - `domain` takes the granted domain;
  - `full` is set to 1;
  - `last_grant` takes the granted domain.
- **Drain:** on `out_val & out_rdy` with no fire_in, `full` is cleared. In the same edge, `out_msg_control`, `out_msg_data` and `domain` are zeroed so nothing stale from a domain remains visible.
- **Hold:** `last_grant` changes only on fire_in, never on an unaccepted grant.
- **Domain stability:** `domain` and the payload are constant while `out_val`=1 and `out_rdy`=0.
- **Simultaneous drain and fill** (full, `out_rdy`=1, a requester valid): dequeue and enqueue happen in the same cycle and `full` stays 1.
- **Reset mid-operation:** the buffered message is dropped. All outputs go to their reset values asynchronously.
- **No X on `domain`:** `domain` is always 0 or 1 after reset.

## Timing
- Latency: input fire in cycle N means `out_val`=1 with that payload in cycle N+1.
- Throughput: one message per cycle when `out_rdy` is held high.
- `in_rdy_dX` depends combinationally on `in_val_d1`, `in_val_d2`, `out_rdy`, `full` and `last_grant`.
- `out_val`, `out_msg_*` and `domain` are pure register outputs with no combinational path from inputs.
- Under sustained contention with `out_rdy`=1, grants alternate D1, D2, D1, …. Each domain waits at most one message.

## Structure
- **Shared package (`plab4_net_domain_pkg`):**
  - `DOMAIN_D1 = 1'b0`
  - `DOMAIN_D2 = 1'b1`
  - reset value of `last_grant` (`DOMAIN_D2`)
- **Sub-module `plab4_net_rr_arb2`:**
  - inputs `clk`, `reset`, `req[1:0]`, `fire`;
  - outputs one-hot `grant[1:0]`;
  - owns `last_grant`.
- **Top level:** holds the slot registers, `full` and the ready logic.

## Test plan
- **Reset:**
  - Stimulus: assert `reset`=0 mid-cycle while `full`=1.
  - Response: `out_val`=0, `domain`=0 and payloads 0 immediately. After release, first tie grants D1.
- **Single domain:**
  - Stimulus: D1 sends control 0x11/data 0xA0, 0x12/0xA1, 0x13/0xA2 with `out_rdy`=1.
  - Response: outputs appear one cycle later, back-to-back, `domain`=0 throughout, `in_rdy_d2` stays 0.
- **Contention:**
  - Stimulus: both valid continuously, D1 data 0x1, D2 data 0x2, 6 cycles, `out_rdy`=1.
  - Response: output data 1,2,1,2,1,2 with `domain` 0,1,0,1,0,1.
- **Backpressure:**
  - Stimulus: `out_rdy`=0 for 4 cycles with D2 message 0x55 buffered.
  - Response:
    - `out_val`=1, data 0x55, `domain`=1 stable all 4 cycles;
    - both `in_rdy` low;
    - `last_grant` unchanged;
    - on `out_rdy`=1 the next message loads in the same cycle.
- **Drain clearing:**
  - Stimulus: accept D2 message 0xDEAD, then no inputs.
  - Response: the cycle after the handshake, `out_val`=0, `out_msg_data`=0, `domain`=0.
- **Random:**
  - Stimulus: random valids and `out_rdy` for 10k cycles.
  - Response: the scoreboard sees no loss or duplication, per-domain order is preserved, and the domain tag always matches the source.
